// File: rtl/uart_tx_flow.sv
// 8N1 UART transmitter with a small byte FIFO and RTS/CTS start gating.
// Define UART_TX_FLOW_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_flow #(
   parameter int CLK_DIV        = 104,
   parameter int FIFO_ADDR_BITS = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [7:0]                in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      cts,
   output logic                      tx,
   output logic                      busy,
   output logic [FIFO_ADDR_BITS:0]   fifo_level
);

   localparam int DEPTH = 1 << FIFO_ADDR_BITS;
   localparam int LW    = FIFO_ADDR_BITS + 1;
   localparam int CNT_W = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(CLK_DIV - 1);
   localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);

`ifdef UART_TX_FLOW_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [2:0]                bit_q, bit_d;
   logic [7:0]                sh_q, sh_d;
   logic                      tx_q, tx_d;
   logic                      busy_q, busy_d;
   logic                      cts_meta_q, cts_s_q;
   logic [FIFO_ADDR_BITS-1:0] wr_q, rd_q;
   logic [LW-1:0]             level_q, level_d;
   logic [7:0]                mem [DEPTH];
`ifdef UART_TX_FLOW_PARITY_EN
   logic                      par_q, par_d;
`endif

   logic       push, pop, launch, start_ok;
   logic [7:0] head;

   // in_ready depends on the level only, so a full FIFO refuses even on a pop edge
   assign in_ready   = (level_q != FULL_LVL);
   assign push       = in_valid & in_ready;
   assign head       = mem[rd_q];
   assign start_ok   = (level_q != '0) && !cts_s_q;
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign fifo_level = level_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
`ifdef UART_TX_FLOW_PARITY_EN
      par_d   = par_q;
`endif
      launch  = 1'b0;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            launch = start_ok;
         end
         S_START: begin
            if (cnt_q == '0) begin
               cnt_d   = RELOAD;
               tx_d    = sh_q[0];
               sh_d    = {1'b0, sh_q[7:1]};
               bit_d   = 3'd0;
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DATA: begin
            if (cnt_q == '0) begin
               cnt_d = RELOAD;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_FLOW_PARITY_EN
                  tx_d    = par_q;
                  state_d = S_PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = sh_q[0];
                  sh_d  = {1'b0, sh_q[7:1]};
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
`ifdef UART_TX_FLOW_PARITY_EN
         S_PARITY: begin
            if (cnt_q == '0) begin
               cnt_d   = RELOAD;
               tx_d    = 1'b1;
               state_d = S_STOP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
`endif
         S_STOP: begin
            if (cnt_q == '0) begin
               if (start_ok) begin
                  launch = 1'b1;
               end else begin
                  tx_d    = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
      // Frame start shared by IDLE and back-to-back STOP exit
      if (launch) begin
         pop     = 1'b1;
         sh_d    = head;
         tx_d    = 1'b0;
         busy_d  = 1'b1;
         cnt_d   = RELOAD;
         state_d = S_START;
`ifdef UART_TX_FLOW_PARITY_EN
         par_d   = ^head;
`endif
      end
      level_d = level_q + LW'(push) - LW'(pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         sh_q       <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         cts_meta_q <= 1'b1;
         cts_s_q    <= 1'b1;
         wr_q       <= '0;
         rd_q       <= '0;
         level_q    <= '0;
`ifdef UART_TX_FLOW_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         sh_q       <= sh_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         cts_meta_q <= cts;
         cts_s_q    <= cts_meta_q;
         level_q    <= level_d;
         if (push) wr_q <= wr_q + FIFO_ADDR_BITS'(1);
         if (pop)  rd_q <= rd_q + FIFO_ADDR_BITS'(1);
`ifdef UART_TX_FLOW_PARITY_EN
         par_q      <= par_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_q] <= in_data;
   end

endmodule

// File: tb/tb_uart_tx_flow.sv
// Directed bench for uart_tx_flow at CLK_DIV=4, depth-4 FIFO.
module tb_uart_tx_flow;
   localparam int CLK_DIV = 4;
`ifdef UART_TX_FLOW_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CLK_DIV;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       cts;
   logic       tx;
   logic       busy;
   logic [2:0] fifo_level;

   int checks = 0;
   int errors = 0;

   uart_tx_flow #(.CLK_DIV(CLK_DIV), .FIFO_ADDR_BITS(2)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .cts(cts), .tx(tx), .busy(busy), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Line level for bit slot idx of an 8N1 (or 8E1) frame carrying b
   function automatic logic exp_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
`ifdef UART_TX_FLOW_PARITY_EN
      if (idx == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   // Walks cycles [first,last) of a frame that started at the current edge minus first
   task automatic expect_frame(input logic [7:0] b, input int first, input int last,
                               input int cts_at, input string tag);
      int bad = 0;
      for (int i = first; i < last; i++) begin
         if (tx !== exp_bit(b, i / CLK_DIV) || busy !== 1'b1) bad++;
         if (i == cts_at) cts = 1'b1;
         tick();
      end
      chk(tag, bad, 0);
   endtask

   initial begin
      reset = 1'b1; cts = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      #12;
      chk("rst_tx", tx, 1); chk("rst_busy", busy, 0);
      chk("rst_level", fifo_level, 0); chk("rst_ready", in_ready, 1);
      @(posedge clk); #1; reset = 1'b0;
      tick(); tick(); tick();

      // single frame, minimum latency
      push(8'hA5);
      chk("a5_level_acc", fifo_level, 1); chk("a5_tx_acc", tx, 1);
      tick();
      chk("a5_level_start", fifo_level, 0);
      expect_frame(8'hA5, 0, FRAME, -1, "a5_frame");
      chk("a5_busy_end", busy, 0); chk("a5_tx_end", tx, 1);

      // queued under cts=1, released, back-to-back
      cts = 1'b1;
      tick(); tick(); tick();
      push(8'h11); push(8'h22); push(8'h33);
      begin
         int bad = 0;
         for (int i = 0; i < 3; i++) begin if (tx !== 1'b1) bad++; tick(); end
         chk("hold_tx_idle", bad, 0);
      end
      chk("hold_level", fifo_level, 3); chk("hold_ready", in_ready, 1);
      cts = 1'b0;
      tick(); chk("cts_edge1_tx", tx, 1);
      tick(); chk("cts_edge2_tx", tx, 1);
      tick(); chk("cts_edge3_tx", tx, 0); chk("b2b_level0", fifo_level, 2);
      expect_frame(8'h11, 0, FRAME, -1, "b2b_f11");
      chk("b2b_level1", fifo_level, 1);
      expect_frame(8'h22, 0, FRAME, -1, "b2b_f22");
      chk("b2b_level2", fifo_level, 0);
      expect_frame(8'h33, 0, FRAME, -1, "b2b_f33");
      chk("b2b_busy_end", busy, 0); chk("b2b_tx_end", tx, 1);

      // cts raised mid-frame: frame completes, next one waits
      push(8'h3C);
      push(8'h5A);
      chk("pp_tx_start", tx, 0); chk("pp_level", fifo_level, 1);
      expect_frame(8'h3C, 0, FRAME, 2 * CLK_DIV + 3 * CLK_DIV, "midcts_f3c");
      chk("midcts_tx", tx, 1); chk("midcts_busy", busy, 0); chk("midcts_level", fifo_level, 1);
      begin
         int bad = 0;
         for (int i = 0; i < 10; i++) begin if (tx !== 1'b1 || busy !== 1'b0) bad++; tick(); end
         chk("midcts_gated", bad, 0);
      end
      cts = 1'b0;
      tick(); tick(); chk("rects_edge2_tx", tx, 1);
      tick(); chk("rects_edge3_tx", tx, 0);
      expect_frame(8'h5A, 0, FRAME, -1, "rects_f5a");
      chk("rects_busy_end", busy, 0);

      // full FIFO back-pressure
      cts = 1'b1;
      tick(); tick(); tick();
      push(8'h01); push(8'h02); push(8'h03); push(8'h04);
      chk("full_ready", in_ready, 0); chk("full_level", fifo_level, 4);
      in_data = 8'h55; in_valid = 1'b1;
      tick(); tick();
      chk("full_hold_level", fifo_level, 4); chk("full_hold_ready", in_ready, 0);
      cts = 1'b0;
      tick(); tick(); chk("full_e2_level", fifo_level, 4);
      tick();
      chk("full_pop_tx", tx, 0); chk("full_pop_level", fifo_level, 3); chk("full_pop_ready", in_ready, 1);
      tick();
      chk("full_refill_level", fifo_level, 4);
      in_valid = 1'b0;
      expect_frame(8'h01, 1, FRAME, -1, "full_f01");
      expect_frame(8'h02, 0, FRAME, -1, "full_f02");
      expect_frame(8'h03, 0, FRAME, -1, "full_f03");
      expect_frame(8'h04, 0, FRAME, -1, "full_f04");
      expect_frame(8'h55, 0, FRAME, -1, "full_f55");
      chk("full_busy_end", busy, 0); chk("full_level_end", fifo_level, 0);

      // asynchronous reset during data bit 5
      push(8'hFF);
      push(8'h00);
      expect_frame(8'hFF, 0, 6 * CLK_DIV + 2, -1, "rst_pre_fff");
      #3 reset = 1'b1;
      #1;
      chk("arst_tx", tx, 1); chk("arst_busy", busy, 0);
      chk("arst_level", fifo_level, 0); chk("arst_ready", in_ready, 1);
      @(posedge clk); #1; reset = 1'b0;
      begin
         int bad = 0;
         for (int i = 0; i < 20; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0) bad++;
            tick();
         end
         chk("arst_quiet", bad, 0);
      end
      push(8'h00);
      tick();
      expect_frame(8'h00, 0, FRAME, -1, "arst_f00");

      // parity/no-parity frame length
      push(8'h07);
      tick();
      expect_frame(8'h07, 0, FRAME, -1, "f07");
      chk("f07_busy_end", busy, 0); chk("f07_tx_end", tx, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
